// File: rtl/serial_bit_feeder.sv
// serial_bit_feeder: parallel-to-serial stage feeding the sequence detector.
// Accepts WIDTH-bit words over valid/ready and emits one registered bit per
// clock. Back-to-back words come out as a gapless stream.
// Optional build macro SER_PARITY_EN appends an even-parity bit to each word.
//
// state | meaning
// IDLE  | no word in flight, ser_valid low, ready for a load
// SHIFT | a frame is on ser_out, one bit per clock
module serial_bit_feeder #(
    parameter int WIDTH     = 8,
    parameter bit MSB_FIRST = 1'b1
) (
    input  logic             clock,
    input  logic             reset,
    input  logic [WIDTH-1:0] load_data,
    input  logic             load_valid,
    output logic             load_ready,
    output logic             ser_out,
    output logic             ser_valid,
    output logic             busy,
    output logic             word_done
);

`ifdef SER_PARITY_EN
    localparam int FRAME = WIDTH + 1;
`else
    localparam int FRAME = WIDTH;
`endif
    localparam int CW = $clog2(FRAME);
    // LAST is the counter value while the final bit of a frame is on ser_out;
    // PRE is the value one bit earlier, so word_done lands with the last bit.
    localparam logic [CW-1:0] LAST = CW'(FRAME - 1);
    localparam logic [CW-1:0] PRE  = CW'(FRAME - 2);
    localparam logic [CW-1:0] ONE  = CW'(1);

    typedef enum logic {IDLE, SHIFT} state_t;

    state_t           state;
    logic [WIDTH-1:0] shreg;
    logic [CW-1:0]    cnt;
    logic             accept;
    logic             head_load;
    logic             head_shreg;
    logic             next_bit;
    logic [WIDTH-1:0] load_rest;
    logic [WIDTH-1:0] shreg_rest;

    // Ready while idle or while the final bit of the current frame is shown,
    // which lets the next word follow without a bubble.
    assign load_ready = (state == IDLE) || ((state == SHIFT) && (cnt == LAST));
    assign accept     = load_valid && load_ready;

    // Head bit and remaining bits for both the incoming word and the register.
    always_comb begin
        if (MSB_FIRST) begin
            head_load  = load_data[WIDTH-1];
            load_rest  = load_data << 1;
            head_shreg = shreg[WIDTH-1];
            shreg_rest = shreg << 1;
        end else begin
            head_load  = load_data[0];
            load_rest  = load_data >> 1;
            head_shreg = shreg[0];
            shreg_rest = shreg >> 1;
        end
    end

`ifdef SER_PARITY_EN
    logic par;

    // Parity of the accepted word, shown after its last data bit.
    always_ff @(posedge clock) begin
        if (reset)
            par <= 1'b0;
        else if (accept)
            par <= ^load_data;
    end

    // After the last data bit the parity bit takes the serial slot.
    always_comb begin
        next_bit = head_shreg;
        if (cnt == PRE)
            next_bit = par;
    end
`else
    // Without parity every slot carries a data bit.
    always_comb begin
        next_bit = head_shreg;
    end
`endif

    // Frame sequencer: load, shift one bit per clock, reload or go idle.
    always_ff @(posedge clock) begin
        if (reset) begin
            state     <= IDLE;
            shreg     <= '0;
            cnt       <= '0;
            ser_out   <= 1'b0;
            ser_valid <= 1'b0;
            busy      <= 1'b0;
            word_done <= 1'b0;
        end else if (accept) begin
            state     <= SHIFT;
            shreg     <= load_rest;
            cnt       <= '0;
            ser_out   <= head_load;
            ser_valid <= 1'b1;
            busy      <= 1'b1;
            word_done <= 1'b0;
        end else if ((state == SHIFT) && (cnt != LAST)) begin
            cnt       <= cnt + ONE;
            shreg     <= shreg_rest;
            ser_out   <= next_bit;
            word_done <= (cnt == PRE);
        end else begin
            state     <= IDLE;
            cnt       <= '0;
            ser_out   <= 1'b0;
            ser_valid <= 1'b0;
            busy      <= 1'b0;
            word_done <= 1'b0;
        end
    end

endmodule

// File: tb/tb_serial_bit_feeder.sv
// Bench for serial_bit_feeder: an MSB-first and an LSB-first instance share
// stimulus; a queue model of pending frame bits predicts every output.
module tb_serial_bit_feeder;

    logic       clock = 1'b0;
    logic       reset = 1'b1;
    logic [7:0] load_data = 8'hFF;
    logic       load_valid = 1'b1;

    logic m_ready, m_out, m_valid, m_busy, m_wd;
    logic l_ready, l_out, l_valid, l_busy, l_wd;

    int n_checks = 0;
    int n_errors = 0;
    bit model_ok = 0;

    bit qm[$];
    bit ql[$];

`ifdef SER_PARITY_EN
    localparam int FR = 9;
`else
    localparam int FR = 8;
`endif

    always #5 clock = ~clock;

    serial_bit_feeder #(.WIDTH(8), .MSB_FIRST(1'b1)) dut_m (
        .clock(clock), .reset(reset), .load_data(load_data), .load_valid(load_valid),
        .load_ready(m_ready), .ser_out(m_out), .ser_valid(m_valid), .busy(m_busy),
        .word_done(m_wd)
    );

    serial_bit_feeder #(.WIDTH(8), .MSB_FIRST(1'b0)) dut_l (
        .clock(clock), .reset(reset), .load_data(load_data), .load_valid(load_valid),
        .load_ready(l_ready), .ser_out(l_out), .ser_valid(l_valid), .busy(l_busy),
        .word_done(l_wd)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Bit idx of a transmitted frame: data bits in order, then optional parity.
    function automatic bit frame_bit(input logic [7:0] d, input int idx, input bit msb);
        if (idx >= 8) return ^d;
        return msb ? d[7-idx] : d[idx];
    endfunction

    // Model: queue of bits still to appear; head is the bit on ser_out now.
    always @(posedge clock) begin
        bit rdy;
        if (reset) begin
            qm.delete();
            ql.delete();
            model_ok = 1;
        end else begin
            rdy = (qm.size() <= 1);
            if (qm.size() > 0) begin
                void'(qm.pop_front());
                void'(ql.pop_front());
            end
            if (load_valid && rdy) begin
                for (int i = 0; i < FR; i++) begin
                    qm.push_back(frame_bit(load_data, i, 1'b1));
                    ql.push_back(frame_bit(load_data, i, 1'b0));
                end
            end
        end
    end

    // Every-cycle comparison of both instances against the model.
    always @(negedge clock) begin
        if (model_ok) begin
            check("m.ser_valid",  32'(m_valid), 32'(qm.size() > 0));
            check("m.ser_out",    32'(m_out),   32'(qm.size() > 0 ? qm[0] : 1'b0));
            check("m.word_done",  32'(m_wd),    32'(qm.size() == 1));
            check("m.busy",       32'(m_busy),  32'(qm.size() > 0));
            check("m.load_ready", 32'(m_ready), 32'(qm.size() <= 1));
            check("l.ser_valid",  32'(l_valid), 32'(ql.size() > 0));
            check("l.ser_out",    32'(l_out),   32'(ql.size() > 0 ? ql[0] : 1'b0));
            check("l.word_done",  32'(l_wd),    32'(ql.size() == 1));
            check("l.busy",       32'(l_busy),  32'(ql.size() > 0));
            check("l.load_ready", 32'(l_ready), 32'(ql.size() <= 1));
        end
    end

    logic [31:0] s_m, s_l, s_v, s_wd, s_rdy, s_mod;

    // Sample n consecutive cycles (first sample at the current negedge);
    // first sample is oldest bit. Drops load_valid after sample drop_at.
    task automatic cap(input int n, input int drop_at, input logic [7:0] new_data);
        s_m = 0; s_l = 0; s_v = 0; s_wd = 0; s_rdy = 0; s_mod = 0;
        for (int i = 0; i < n; i++) begin
            if (i > 0) @(negedge clock);
            s_m   = (s_m << 1) | 32'(m_out);
            s_l   = (s_l << 1) | 32'(l_out);
            s_v   = (s_v << 1) | 32'(m_valid);
            s_wd  = (s_wd << 1) | 32'(m_wd);
            s_rdy = (s_rdy << 1) | 32'(m_ready);
            s_mod = (s_mod << 1) | 32'(qm.size() > 0 ? qm[0] : 1'b0);
            if (i == 0) load_data = new_data;
            if (i == drop_at) load_valid = 1'b0;
        end
    endtask

`ifdef SER_PARITY_EN
    localparam logic [31:0] E2_M = 32'b11000100100, E2_L = 32'b00100011100;
    localparam logic [31:0] E2_V = 32'b11111111100, E2_WD = 32'b00000000100;
    localparam logic [31:0] E2_R = 32'b00000000111;
    localparam logic [31:0] E3_M = 32'b11000100101000100000, E3_V = 32'b11111111111111111100;
    localparam logic [31:0] E3_R = 32'b00000000100000000111, E3_WD = 32'b00000000100000000100;
    localparam logic [31:0] E4_L = 32'b100000001, E4_M = 32'b000000011;
`else
    localparam logic [31:0] E2_M = 32'b1100010000, E2_L = 32'b0010001100;
    localparam logic [31:0] E2_V = 32'b1111111100, E2_WD = 32'b0000000100;
    localparam logic [31:0] E2_R = 32'b0000000111;
    localparam logic [31:0] E3_M = 32'b110001000100010000, E3_V = 32'b111111111111111100;
    localparam logic [31:0] E3_R = 32'b000000010000000111, E3_WD = 32'b000000010000000100;
    localparam logic [31:0] E4_L = 32'b10000000, E4_M = 32'b00000001;
`endif

    initial begin
        // Reset held two cycles with a load offered: nothing is accepted.
        @(negedge clock);
        @(negedge clock);
        check("rst.ser_valid",  32'(m_valid), 32'd0);
        check("rst.ser_out",    32'(m_out),   32'd0);
        check("rst.load_ready", 32'(m_ready), 32'd1);
        check("rst.word_done",  32'(m_wd),    32'd0);
        reset = 1'b0;
        load_valid = 1'b0;
        @(negedge clock);
        check("rst.no_load", 32'(m_valid), 32'd0);

        // Single word C4.
        load_valid = 1'b1; load_data = 8'hC4;
        @(negedge clock);
        cap(FR + 2, 0, 8'hC4);
        check("single.bits_msb", s_m,   E2_M);
        check("single.bits_lsb", s_l,   E2_L);
        check("single.valid",    s_v,   E2_V);
        check("single.word_done", s_wd, E2_WD);
        check("single.ready",    s_rdy, E2_R);
        check("single.model",    s_mod, E2_M);

        // Back-to-back C4 then 44 with load_valid held.
        load_valid = 1'b1; load_data = 8'hC4;
        @(negedge clock);
        cap(2 * FR + 2, FR, 8'h44);
        check("b2b.bits",      s_m,   E3_M);
        check("b2b.valid",     s_v,   E3_V);
        check("b2b.ready",     s_rdy, E3_R);
        check("b2b.word_done", s_wd,  E3_WD);

        // Word 01: LSB-first instance leads with the 1.
        load_valid = 1'b1; load_data = 8'h01;
        @(negedge clock);
        cap(FR, 0, 8'h01);
        check("lsb.bits", s_l, E4_L);
        check("msb.bits_01", s_m, E4_M);
        @(negedge clock);

        // Reset after three bits of AA, then a fresh load restarts at bit 0.
        load_valid = 1'b1; load_data = 8'hAA;
        @(negedge clock);
        cap(3, 0, 8'hAA);
        check("midrst.bits", s_m, 32'b101);
        reset = 1'b1;
        @(negedge clock);
        check("midrst.ser_valid", 32'(m_valid), 32'd0);
        check("midrst.word_done", 32'(m_wd),    32'd0);
        check("midrst.ready",     32'(m_ready), 32'd1);
        reset = 1'b0;
        load_valid = 1'b1; load_data = 8'hAA;
        @(negedge clock);
        cap(3, 0, 8'hAA);
        check("restart.bits",  s_m, 32'b101);
        check("restart.valid", s_v, 32'b111);
        repeat (FR) @(negedge clock);

`ifdef SER_PARITY_EN
        // Parity frames: 07 -> parity 1, 03 -> parity 0.
        load_valid = 1'b1; load_data = 8'h07;
        @(negedge clock);
        cap(10, 0, 8'h07);
        check("par07.bits",      s_m,  32'b0000011110);
        check("par07.valid",     s_v,  32'b1111111110);
        check("par07.word_done", s_wd, 32'b0000000010);
        load_valid = 1'b1; load_data = 8'h03;
        @(negedge clock);
        cap(10, 0, 8'h03);
        check("par03.bits", s_m, 32'b0000001100);
`endif

        // Random traffic with occasional resets, checked by the model.
        repeat (3000) begin
            @(negedge clock);
            reset      = ($urandom_range(0, 99) == 0);
            load_valid = ($urandom_range(0, 3) != 0);
            load_data  = 8'($urandom);
        end
        @(negedge clock);
        load_valid = 1'b0;
        reset = 1'b0;
        repeat (2 * FR) @(negedge clock);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
